mii_frame_checker: RTL and testbench
====================================

# mii_frame_checker

Receive-side checker for the 1.6T MII test path. It consumes the word stream that the MII generator emits (`o_tx_data`/`o_tx_ctrl`, looped back) and aligns to its idle/data frame structure. For every frame it verifies the data-run length, the idle-run length and the idle control code. It reports per-event pulses, lock status and saturating frame/error counters for testbench scoreboarding and later on-chip loopback.

## Interface
Parameters:
- `DATA_WIDTH`, 64: width of one MII word.
- `CTRL_WIDTH`, 1: control width. Only bit 0 is used. 1 = control (idle) word, 0 = data word.
- `IDLE_LENGTH`, 16: required number of consecutive idle words between data runs.
- `DATA_LENGTH`, 64: required number of consecutive data words per frame.
- `IDLE_WORD`, {DATA_WIDTH/8{8'h07}}: the only legal payload for a control word.
- `COUNT_WIDTH`, 16: width of the frame and error counters.

Ports:
- `clk`  in  1  single clock; everything samples on its rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_rx_data`  in  DATA_WIDTH  received word.
- `i_rx_ctrl`  in  CTRL_WIDTH  received control flag.
- `o_locked`  out  1  frame alignment established and the last completed check passed.
- `o_frame_done`  out  1  one-cycle pulse when a data run of exactly DATA_LENGTH ends.
- `o_len_err`  out  1  one-cycle pulse on a data-run length error.
- `o_idle_err`  out  1  one-cycle pulse on an idle-run length error.
- `o_code_err`  out  1  one-cycle pulse when a control word's payload is not IDLE_WORD.
- `o_frame_count`  out  COUNT_WIDTH  number of good frames; saturates at all-ones.
- `o_error_count`  out  COUNT_WIDTH  number of cycles with any error pulse; saturates.

## Operation
- The FSM has three states: HUNT, DATA, IDLE. It keeps one run counter, `run_cnt`, of width $clog2(max(IDLE_LENGTH,DATA_LENGTH)+2). The counter saturates and never wraps.
- **HUNT** (state after reset):
  - Run-length checks and code checks are suppressed.
  - Go to DATA with `run_cnt`=1 on the first data word that directly follows a control word (ctrl 1→0 edge). Any other word leaves the FSM in HUNT.
- **DATA**:
  - A data word increments `run_cnt`.
  - If a data word arrives when `run_cnt`==DATA_LENGTH: pulse `o_len_err` (overrun), clear `o_locked`, go to HUNT.
  - A control word ends the run:
    - If `run_cnt`==DATA_LENGTH: pulse `o_frame_done`, increment `o_frame_count`, set `o_locked`.
    - Otherwise: pulse `o_len_err` (underrun) and clear `o_locked`.
    - In both cases go to IDLE with `run_cnt`=1.
- **IDLE**:
  - A control word increments `run_cnt`.
  - If a control word arrives when `run_cnt`==IDLE_LENGTH: pulse `o_idle_err`, clear `o_locked`, go to HUNT.
  - A data word ends the idle run:
    - If `run_cnt`!=IDLE_LENGTH: pulse `o_idle_err` and clear `o_locked`.
    - In both cases go to DATA with `run_cnt`=1.
- **Code check** (DATA and IDLE states only): when ctrl=1 and `i_rx_data`!=IDLE_WORD, pulse `o_code_err` and clear `o_locked`. The word still counts as an idle word for length purposes.
- **Simultaneous events**:
  - Several error pulses may assert in the same cycle.
  - `o_error_count` increments by exactly 1 in any cycle where any error pulse is asserted.
  - An error and `o_frame_done` can never coincide; a code error on the word that ends a good data run is the one exception. In that case both `o_frame_done` and `o_code_err` pulse, the frame counts, and `o_locked` ends up 0 (the clear has priority).
- **Counters**: both hold at 2^COUNT_WIDTH−1 once reached. Software clears them only through `i_rst`.

## Timing
- All outputs are registered. A condition caused by the word sampled at edge N is visible after edge N, and each pulse is exactly one cycle wide.
- Counter updates appear in the same cycle as the corresponding pulse.
- Reset (asynchronous, effective immediately):
  - FSM goes to HUNT and `run_cnt`=0.
  - All pulse outputs are 0, `o_locked`=0, and both counters are 0.
- Reset released mid-frame: the checker stays in HUNT and reports nothing until the next ctrl 1→0 edge. The first data run after that edge is fully checked.
- Throughput: one word per clock, no backpressure, no stall states.

## Test plan
- **Nominal stream:** after reset, drive 16 idle / 64 data repeatedly for 10 frames → `o_frame_done` pulses 10 times, each 1 cycle after the first idle following each data run; `o_frame_count`=10, `o_error_count`=0, `o_locked`=1 from the first frame_done on.
- **Data underrun:** drive one frame with 63 data words → a single `o_len_err` pulse, `o_locked`=0, `o_error_count`=1, no frame_done. The next good frame re-asserts `o_locked`.
- **Data overrun:** drive 65 data words → `o_len_err` 1 cycle after the 65th word and the FSM enters HUNT. The following 16 idle / 64 data words give no report until the next aligned frame, which reports `o_frame_done`.
- **Idle errors:** drive 15 idle words, then data → `o_idle_err` pulses. Drive 17 idle words → `o_idle_err` on the 17th and the FSM returns to HUNT.
- **Bad code:** drive ctrl=1 with data 64'h0707070707070706 in the middle of an idle run → `o_code_err` pulses once, the idle length is still counted as 16 (no `o_idle_err`), and `o_error_count` increments by 1.
- **Reset/saturation:**
  - Assert `i_rst` asynchronously mid-data → all outputs go to 0 immediately.
  - With COUNT_WIDTH=4, run 20 good frames → `o_frame_count` holds at 15.

Source files
------------

// File: rtl/mii_frame_checker.sv
// Receive-side checker for the looped-back MII test stream: aligns to the
// idle/data frame structure and checks data-run length, idle-run length and idle code.
module mii_frame_checker #(
  parameter int                    DATA_WIDTH  = 64,
  parameter int                    CTRL_WIDTH  = 1,
  parameter int                    IDLE_LENGTH = 16,
  parameter int                    DATA_LENGTH = 64,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = {DATA_WIDTH/8{8'h07}},
  parameter int                    COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   i_rst,
  input  logic [DATA_WIDTH-1:0]  i_rx_data,
  input  logic [CTRL_WIDTH-1:0]  i_rx_ctrl,
  output logic                   o_locked,
  output logic                   o_frame_done,
  output logic                   o_len_err,
  output logic                   o_idle_err,
  output logic                   o_code_err,
  output logic [COUNT_WIDTH-1:0] o_frame_count,
  output logic [COUNT_WIDTH-1:0] o_error_count,
  output logic [1:0]             o_dbg_state
);

  localparam int MAX_LEN = (IDLE_LENGTH > DATA_LENGTH) ? IDLE_LENGTH : DATA_LENGTH;
  localparam int RUN_W   = $clog2(MAX_LEN + 2);
  localparam logic [RUN_W-1:0] DATA_LEN_C = RUN_W'(DATA_LENGTH);
  localparam logic [RUN_W-1:0] IDLE_LEN_C = RUN_W'(IDLE_LENGTH);
  localparam logic [RUN_W-1:0] RUN_ONE    = RUN_W'(1);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    DATA = 2'd1,
    IDLE = 2'd2
  } state_t;

  state_t           state;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_inc;
  logic             prev_ctrl;
  logic             is_ctrl;
  logic             done_ev;
  logic             len_ev;
  logic             idle_ev;
  logic             code_ev;
  logic             any_err;

  assign o_dbg_state = state;

  // The stream has no handshake: one word is consumed on every rising edge.
  always_comb begin
    is_ctrl = i_rx_ctrl[0];
    run_inc = (run_cnt == '1) ? run_cnt : run_cnt + RUN_ONE;
    done_ev = 1'b0;
    len_ev  = 1'b0;
    idle_ev = 1'b0;
    code_ev = 1'b0;
    if (state == DATA) begin
      done_ev = is_ctrl && (run_cnt == DATA_LEN_C);
      len_ev  = is_ctrl ? (run_cnt != DATA_LEN_C) : (run_cnt == DATA_LEN_C);
    end
    if (state == IDLE) begin
      idle_ev = is_ctrl ? (run_cnt == IDLE_LEN_C) : (run_cnt != IDLE_LEN_C);
    end
    if (state != HUNT) begin
      code_ev = is_ctrl && (i_rx_data != IDLE_WORD);
    end
    any_err = len_ev | idle_ev | code_ev;
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= HUNT;
      run_cnt       <= '0;
      prev_ctrl     <= 1'b0;
      o_locked      <= 1'b0;
      o_frame_done  <= 1'b0;
      o_len_err     <= 1'b0;
      o_idle_err    <= 1'b0;
      o_code_err    <= 1'b0;
      o_frame_count <= '0;
      o_error_count <= '0;
    end else begin
      prev_ctrl    <= is_ctrl;
      o_frame_done <= done_ev;
      o_len_err    <= len_ev;
      o_idle_err   <= idle_ev;
      o_code_err   <= code_ev;

      // An error clears lock even when the same word completes a good frame.
      if (any_err) begin
        o_locked <= 1'b0;
      end else if (done_ev) begin
        o_locked <= 1'b1;
      end

      if (done_ev && (o_frame_count != '1)) begin
        o_frame_count <= o_frame_count + COUNT_WIDTH'(1);
      end
      if (any_err && (o_error_count != '1)) begin
        o_error_count <= o_error_count + COUNT_WIDTH'(1);
      end

      case (state)
        HUNT: begin
          if (!is_ctrl && prev_ctrl) begin
            state   <= DATA;
            run_cnt <= RUN_ONE;
          end
        end
        DATA: begin
          if (is_ctrl) begin
            state   <= IDLE;
            run_cnt <= RUN_ONE;
          end else if (run_cnt == DATA_LEN_C) begin
            state   <= HUNT;
            run_cnt <= '0;
          end else begin
            run_cnt <= run_inc;
          end
        end
        IDLE: begin
          if (!is_ctrl) begin
            state   <= DATA;
            run_cnt <= RUN_ONE;
          end else if (run_cnt == IDLE_LEN_C) begin
            state   <= HUNT;
            run_cnt <= '0;
          end else begin
            run_cnt <= run_inc;
          end
        end
        default: begin
          state   <= HUNT;
          run_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mii_frame_checker.sv
// Bench for mii_frame_checker: directed and random run sequences scored against a
// run-level reference model; a second instance with 4-bit counters checks saturation.
module tb_mii_frame_checker;

  localparam int          DW     = 64;
  localparam int          IL     = 16;
  localparam int          DL     = 64;
  localparam logic [63:0] IDLE_W = {8{8'h07}};
  localparam logic [63:0] BAD_W  = 64'h0707070707070706;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] rx_data = IDLE_W;
  logic [0:0]    rx_ctrl = 1'b0;

  logic        a_locked, a_done, a_len, a_idle, a_code;
  logic [15:0] a_fc, a_ec;
  logic [1:0]  a_state;
  logic        s_locked, s_done, s_len, s_idle, s_code;
  logic [3:0]  s_fc, s_ec;
  logic [1:0]  s_state;

  mii_frame_checker dut (
    .clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_ctrl(rx_ctrl),
    .o_locked(a_locked), .o_frame_done(a_done), .o_len_err(a_len),
    .o_idle_err(a_idle), .o_code_err(a_code), .o_frame_count(a_fc),
    .o_error_count(a_ec), .o_dbg_state(a_state)
  );

  mii_frame_checker #(.COUNT_WIDTH(4)) dut_sat (
    .clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_ctrl(rx_ctrl),
    .o_locked(s_locked), .o_frame_done(s_done), .o_len_err(s_len),
    .o_idle_err(s_idle), .o_code_err(s_code), .o_frame_count(s_fc),
    .o_error_count(s_ec), .o_dbg_state(s_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // stimulus words of the current segment and expected pulses {done,len,idle,code}
  logic          seg_ctrl[$];
  logic [DW-1:0] seg_data[$];
  logic [3:0]    exp_q[$];

  int m_frames = 0;
  int m_errs   = 0;
  logic m_locked = 1'b0;

  function automatic logic [31:0] sat_cnt(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic add_run(input logic c, input int len, input int bad_idx, input logic [DW-1:0] bad_val);
    for (int k = 0; k < len; k++) begin
      seg_ctrl.push_back(c);
      if (c) seg_data.push_back((k == bad_idx) ? bad_val : IDLE_W);
      else   seg_data.push_back({$urandom, $urandom});
    end
  endtask

  // Reference model: the segment starts right after reset. A data run is checked
  // once any idle word precedes it; an idle run is checked only when the data run
  // before it was checked and did not overrun.
  task automatic build_expected();
    int         rs[$];
    int         rl[$];
    logic       rc[$];
    logic [3:0] ev[];
    int         n;
    logic       prev_data_ok;
    n = seg_ctrl.size();
    ev = new[n];
    for (int i = 0; i < n; i++) ev[i] = 4'b0000;
    for (int i = 0; i < n; i++) begin
      if (i == 0 || seg_ctrl[i] != seg_ctrl[i-1]) begin
        rs.push_back(i); rl.push_back(1); rc.push_back(seg_ctrl[i]);
      end else begin
        rl[rl.size()-1] = rl[rl.size()-1] + 1;
      end
    end
    prev_data_ok = 1'b0;
    for (int r = 0; r < rs.size(); r++) begin
      int   s;
      int   len;
      logic has_next;
      s = rs[r];
      len = rl[r];
      has_next = (r + 1 < rs.size());
      if (!rc[r]) begin
        prev_data_ok = 1'b0;
        if (r > 0) begin
          if (len > DL) ev[s+DL][2] = 1'b1;
          else begin
            prev_data_ok = 1'b1;
            if (has_next) begin
              if (len == DL) ev[s+len][3] = 1'b1;
              else           ev[s+len][2] = 1'b1;
            end
          end
        end
      end else if (prev_data_ok) begin
        for (int k = 0; k < len && k <= IL; k++)
          if (seg_data[s+k] != IDLE_W) ev[s+k][0] = 1'b1;
        if (len > IL) ev[s+IL][1] = 1'b1;
        else if (has_next && len != IL) ev[s+len][1] = 1'b1;
      end
    end
    for (int i = 0; i < n; i++) exp_q.push_back(ev[i]);
  endtask

  task automatic score(input string name);
    logic [3:0] e;
    e = exp_q.pop_front();
    if (e[3]) m_frames++;
    if (|e[2:0]) begin
      m_errs++;
      m_locked = 1'b0;
    end else if (e[3]) begin
      m_locked = 1'b1;
    end
    check({name, " pulses"}, {28'd0, a_done, a_len, a_idle, a_code}, {28'd0, e});
    check({name, " locked"}, {31'd0, a_locked}, {31'd0, m_locked});
    check({name, " frame_cnt"}, {16'd0, a_fc}, sat_cnt(m_frames, 16));
    check({name, " error_cnt"}, {16'd0, a_ec}, sat_cnt(m_errs, 16));
    check({name, " sat_frame_cnt"}, {28'd0, s_fc}, sat_cnt(m_frames, 4));
    check({name, " sat_error_cnt"}, {28'd0, s_ec}, sat_cnt(m_errs, 4));
  endtask

  // driver: inputs change on the falling edge, outputs sampled 1 ns after the rising edge
  task automatic run_segment(input string name);
    build_expected();
    while (seg_ctrl.size() > 0) begin
      @(negedge clk);
      rx_ctrl = seg_ctrl.pop_front();
      rx_data = seg_data.pop_front();
      @(posedge clk);
      #1;
      score(name);
    end
  endtask

  task automatic clear_model();
    m_frames = 0;
    m_errs   = 0;
    m_locked = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " flags"}, {22'd0, a_done, a_len, a_idle, a_code, a_locked,
                            s_done, s_len, s_idle, s_code, s_locked}, 32'd0);
    check({tag, " frame_cnt"}, {16'd0, a_fc}, 32'd0);
    check({tag, " error_cnt"}, {16'd0, a_ec}, 32'd0);
    check({tag, " sat_cnts"}, {24'd0, s_fc, s_ec}, 32'd0);
    check({tag, " state"}, {28'd0, a_state, s_state}, 32'd0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rx_ctrl = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_model();
  endtask

  task automatic good_frames(input int n);
    for (int f = 0; f < n; f++) begin
      add_run(1'b0, DL, -1, IDLE_W);
      add_run(1'b1, IL, -1, IDLE_W);
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    #2 check_reset_state("reset");
    reset_dut();

    // nominal stream: 10 frames
    add_run(1'b1, IL, -1, IDLE_W);
    good_frames(10);
    run_segment("nominal");
    check("nominal frames", {16'd0, a_fc}, 32'd10);
    check("nominal locked", {31'd0, a_locked}, 32'd1);
    reset_dut();

    // data underrun then relock
    add_run(1'b1, IL, -1, IDLE_W);
    good_frames(1);
    add_run(1'b0, 63, -1, IDLE_W); add_run(1'b1, IL, -1, IDLE_W);
    good_frames(1);
    run_segment("underrun");
    reset_dut();

    // data overrun, hunt, realign
    add_run(1'b1, IL, -1, IDLE_W);
    good_frames(1);
    add_run(1'b0, 65, -1, IDLE_W); add_run(1'b1, IL, -1, IDLE_W);
    good_frames(2);
    run_segment("overrun");
    reset_dut();

    // short and long idle runs
    add_run(1'b1, IL, -1, IDLE_W);
    good_frames(1);
    add_run(1'b0, DL, -1, IDLE_W); add_run(1'b1, 15, -1, IDLE_W);
    add_run(1'b0, DL, -1, IDLE_W); add_run(1'b1, 17, -1, IDLE_W);
    good_frames(2);
    run_segment("idle_err");
    reset_dut();

    // bad code mid idle run, then on the word ending a good data run
    add_run(1'b1, IL, -1, IDLE_W);
    add_run(1'b0, DL, -1, IDLE_W); add_run(1'b1, IL, 7, BAD_W);
    add_run(1'b0, DL, -1, IDLE_W); add_run(1'b1, IL, 0, BAD_W);
    good_frames(1);
    run_segment("bad_code");
    reset_dut();

    // random run lengths and corrupted idle words
    add_run(1'b1, IL, -1, IDLE_W);
    for (int r = 0; r < 30; r++) begin
      int sel;
      int dlen;
      int ilen;
      logic [63:0] bv;
      sel  = $urandom_range(0, 9);
      dlen = (sel == 0) ? 63 : (sel == 1) ? 65 : (sel == 2) ? $urandom_range(1, 70) : DL;
      add_run(1'b0, dlen, -1, IDLE_W);
      sel  = $urandom_range(0, 9);
      ilen = (sel == 0) ? 15 : (sel == 1) ? 17 : (sel == 2) ? $urandom_range(1, 20) : IL;
      bv   = IDLE_W ^ {32'd0, $urandom_range(1, 32'hffff)};
      add_run(1'b1, ilen, ($urandom_range(0, 5) == 0) ? $urandom_range(0, ilen - 1) : -1, bv);
    end
    run_segment("random");
    reset_dut();

    // counter saturation
    add_run(1'b1, IL, -1, IDLE_W);
    good_frames(20);
    run_segment("saturate");
    check("sat hold 15", {28'd0, s_fc}, 32'd15);
    check("frames 20", {16'd0, a_fc}, 32'd20);
    reset_dut();

    // asynchronous reset in the middle of a data run
    add_run(1'b1, IL, -1, IDLE_W);
    good_frames(2);
    add_run(1'b0, 30, -1, IDLE_W);
    run_segment("pre_rst");
    #2 rst = 1'b1;
    #1 check_reset_state("mid_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_model();
    add_run(1'b0, 34, -1, IDLE_W); add_run(1'b1, IL, -1, IDLE_W);
    good_frames(1);
    run_segment("post_rst");
    check("post_rst frames", {16'd0, a_fc}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
